// File: rtl/multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multi_pkg
//  Description : Shared definitions for the multi_collect block: the
//                collector FSM state type, the per-lane latency rule and
//                default parameter values.
//  Revision    : 1.0  initial release
// ============================================================================
package multi_pkg;

    // Default configuration of the multi_collect wrapper
    localparam int C_NUM_LANES  = 2;
    localparam int C_LANE_WIDTH = 32;
    localparam int C_BASE_LAT   = 3;

    // Collector FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // A lane's latency grows by one cycle when its operand is odd
    function automatic int lane_lat(input int base, input logic lsb);
        return base + (lsb ? 1 : 0);
    endfunction

endpackage : multi_pkg
`default_nettype wire

// File: rtl/multi_collect_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_collect_if
//  Description : Request/result bundle of multi_collect.
//                start/ready : request handshake (accept = start & ready)
//                inp         : wide operand, sampled on accept
//                done/ack    : result handshake (result taken on done & ack)
//                out         : assembled wide result, qualified by done
//                Modport slave is the collector, master is its user.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_collect_if #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 32
);
    logic                              start;
    logic                              ready;
    logic [NUM_LANES*LANE_WIDTH-1:0]   inp;
    logic                              done;
    logic                              ack;
    logic [NUM_LANES*LANE_WIDTH-1:0]   out;

    modport slave  (input  start, inp, ack, output ready, done, out);
    modport master (output start, inp, ack, input  ready, done, out);
endinterface : multi_collect_if
`default_nettype wire

// File: rtl/multi_lane.sv
`default_nettype none
// ============================================================================
//  Module      : multi_lane
//  Description : Multi-cycle lane unit. Captures its operand on i_start,
//                counts down a data-dependent latency and pulses o_done for
//                one cycle together with o_result = operand + 1.
//  Ports       : clock, reset (async, active low)
//                i_start   - begin an operation with i_operand
//                i_operand - lane operand
//                o_done    - one-cycle completion pulse
//                o_result  - lane result, valid with o_done
//  Revision    : 1.0  initial release
// ============================================================================
module multi_lane
    import multi_pkg::*;
#(
    parameter int LANE_WIDTH = C_LANE_WIDTH,
    parameter int BASE_LAT   = C_BASE_LAT
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  i_start,
    input  wire logic [LANE_WIDTH-1:0] i_operand,
    output logic                       o_done,
    output logic [LANE_WIDTH-1:0]      o_result
);

    // Must hold BASE_LAT+1 without overflow
    localparam int CNT_W = $clog2(BASE_LAT + 2);

    logic [CNT_W-1:0]      r_cnt;
    logic [LANE_WIDTH-1:0] r_operand;

    // Counter loads LAT on the accept edge, so it reads 1 exactly LAT
    // cycles after the accept cycle; zero means idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_operand <= '0;
        end else if (i_start) begin
            r_operand <= i_operand;
            r_cnt     <= CNT_W'(lane_lat(BASE_LAT, i_operand[0]));
        end else if (r_cnt != '0) begin
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done   = (r_cnt == CNT_W'(1));
    assign o_result = r_operand + LANE_WIDTH'(1);

endmodule : multi_lane
`default_nettype wire

// File: rtl/multi_collect.sv
`default_nettype none
// ============================================================================
//  Module      : multi_collect
//  Description : Splits a wide operand over NUM_LANES multi_lane units,
//                starts all lanes together, captures each lane result as it
//                completes and presents the assembled result under a
//                done/ack handshake.
//  Ports       : clock, reset (async, active low)
//                bus (multi_collect_if.slave): start/ready, inp, done/ack, out
//  Options     : MULTI_COLLECT_BYPASS_EN - present the result in the cycle
//                the last lane completes, muxing live lane results over the
//                buffers. Undefined: done and out are purely registered and
//                appear one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_collect
    import multi_pkg::*;
#(
    parameter int NUM_LANES  = C_NUM_LANES,
    parameter int LANE_WIDTH = C_LANE_WIDTH,
    parameter int BASE_LAT   = C_BASE_LAT
) (
    input  wire logic       clock,
    input  wire logic       reset,
    multi_collect_if.slave  bus
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_LANES-1:0]   r_mask;
    logic [NUM_LANES-1:0]   w_mask_next;
    logic [NUM_LANES-1:0]   w_lane_done;
    logic                   w_accept;
    logic                   w_run;
    logic                   w_all_done;
    logic                   w_ready;
    logic                   w_done;

    assign w_run      = (r_state == RUN);
    assign w_accept   = (r_state == IDLE) && bus.start;
    // Completions of the current cycle count toward the all-done test
    assign w_mask_next = r_mask | (w_lane_done & {NUM_LANES{w_run}});
    assign w_all_done  = &w_mask_next;

    // ------------------------------------------------------------------
    // Lanes, per-lane result buffers and output assembly
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] w_res;
        logic [LANE_WIDTH-1:0] r_buf;

        multi_lane #(
            .LANE_WIDTH (LANE_WIDTH),
            .BASE_LAT   (BASE_LAT)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .i_start   (w_accept),
            .i_operand (bus.inp[i*LANE_WIDTH +: LANE_WIDTH]),
            .o_done    (w_lane_done[i]),
            .o_result  (w_res)
        );

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_buf <= '0;
            end else if (w_run && w_lane_done[i]) begin
                r_buf <= w_res;
            end
        end

`ifdef MULTI_COLLECT_BYPASS_EN
        // Lanes finishing this cycle have not reached their buffer yet
        assign bus.out[i*LANE_WIDTH +: LANE_WIDTH] =
            (w_run && w_lane_done[i]) ? w_res : r_buf;
`else
        assign bus.out[i*LANE_WIDTH +: LANE_WIDTH] = r_buf;
`endif
    end

    // ------------------------------------------------------------------
    // Lane-done mask: cleared on accept, accumulates during RUN
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= '0;
        end else if (w_run) begin
            r_mask <= w_mask_next;
        end
    end

    // ------------------------------------------------------------------
    // Collector FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_all_done) begin
`ifdef MULTI_COLLECT_BYPASS_EN
                    // Result is already visible, so it may be taken now
                    w_done       = 1'b1;
                    w_state_next = bus.ack ? IDLE : HOLD;
`else
                    w_state_next = HOLD;
`endif
                end
            end
            HOLD: begin
                w_done = 1'b1;
                if (bus.ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.ready = w_ready;
    assign bus.done  = w_done;

endmodule : multi_collect
`default_nettype wire

// File: doc/multi_collect.md
# multi_collect

Parametrised multi-lane wrapper around NUM_LANES instances of a multi-cycle lane unit. Each lane has a data-dependent latency. The block splits a wide operand into lanes, starts every lane together, and captures each lane result as it completes. When all lanes have finished it presents the assembled result under a done/ack handshake. It generalises the fixed two-lane, fixed-timing wrapper to N lanes, variable latency, backpressure and an explicit completion signal.

## Interface
- NUM_LANES, 2: number of lanes, ≥1
- LANE_WIDTH, 32: bits per lane
- BASE_LAT, 3: minimum lane latency in cycles, ≥1
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  block idle, start will be accepted
- inp  in  NUM_LANES*LANE_WIDTH  operand; lane i = inp[i*LANE_WIDTH +: LANE_WIDTH], sampled on accept
- done  out  1  result valid; held until ack
- ack  in  1  consumer takes result when done=1
- out  out  NUM_LANES*LANE_WIDTH  assembled result, lane i in the same slice position as inp

## Operation
- Lane function:
  - out_i = inp_i + 1 mod 2^LANE_WIDTH.
  - Latency LAT_i = BASE_LAT + inp_i[0].
- FSM states: IDLE, RUN, HOLD. Reset value is IDLE.
- IDLE:
  - ready=1.
  - start=1 is an accept. All lanes start in the same cycle and the lane-done mask is cleared. Next state is RUN.
- RUN:
  - ready=0.
  - A lane's done pulse sets its mask bit and writes its result into its lane buffer.
  - When the mask becomes all-ones (counting pulses in the current cycle), next state is HOLD.
- HOLD:
  - done=1 and out is driven from the lane buffers.
  - done & ack moves to IDLE on the next edge.
  - ack while done=0 is ignored.
- start while ready=0 is ignored and no state changes.
- Simultaneous lane completions in one cycle are all captured.
- Outputs outside HOLD:
  - done=0.
  - out shows the lane buffers, i.e. stale data from the previous result. Consumers qualify out with done.
- Reset asserted mid-operation:
  - State goes to IDLE, mask and buffers clear to 0, lane counters clear.
  - No lane done pulse from the aborted operation may appear after reset is released.
- Reset values: ready=1, done=0, out=0.

## Timing
- Accept occurs in cycle T (start & ready high at the rising edge ending T).
- Lane i pulses done for exactly one cycle, in cycle T+LAT_i.
- With the bypass macro defined:
  - done first rises in cycle T+max(LAT_i).
  - In that cycle out comes from live lane outputs for lanes completing that cycle, and from buffers for the rest.
  - Best-case latency is BASE_LAT.
- Without the bypass macro:
  - done first rises in cycle T+max(LAT_i)+1.
  - out comes from buffers only.
- Both configurations: done and out are stable while done=1 and ack=0.
- ready returns to 1 in the cycle after done & ack.
- A new start may then be accepted in that same cycle.
- Minimum accept-to-accept spacing is max(LAT_i)+1 cycles, +1 without bypass.

## Configuration
- MULTI_COLLECT_BYPASS_EN defined:
  - Completion cycle is combinational. done = (state==RUN & mask_next all-ones) | state==HOLD.
  - out muxes the live lane result over the buffer per lane.
- MULTI_COLLECT_BYPASS_EN undefined:
  - done = (state==HOLD) and out = buffers, both purely registered.
  - Latency is one cycle longer.

## Structure
- Shared package multi_pkg holds:
  - the FSM state enum typedef (IDLE/RUN/HOLD);
  - the lane latency function lane_lat(base, lsb);
  - default parameter constants.
- One sub-module, multi_lane, parametrised by LANE_WIDTH and BASE_LAT:
  - captures its operand on start;
  - down-counts LAT;
  - pulses done with its result.
- Top instantiates NUM_LANES multi_lane copies via generate and owns the FSM, mask, buffers and output mux.

## Test plan
All scenarios use NUM_LANES=2, LANE_WIDTH=32, BASE_LAT=3, with the bypass macro defined unless stated.
- Unequal latency: accept in cycle 0 with inp={32'h4, 32'h3}.
  - Lane0 done in cycle 4, lane1 done in cycle 3.
  - done rises in cycle 4 with out={32'h5, 32'h4}.
  - ack in cycle 4 gives ready=1 in cycle 5.
- Wrap-around: inp={32'hFFFF_FFFE, 32'hFFFF_FFFF}.
  - out={32'hFFFF_FFFF, 32'h0}.
  - done in cycle 4.
- Backpressure: ack held low for 5 cycles after done.
  - done and out stay constant.
  - A start pulsed during that window is ignored (ready=0).
- Reset mid-operation: reset asserted in cycle 2 of a run.
  - Immediately ready=1, done=0, out=0.
  - After release, no done occurs without a new start.
- Bypass disabled: repeat the unequal-latency case.
  - done rises in cycle 5 with the same out value.
- Back-to-back: ack in cycle 4, then start in cycle 5 with inp={32'h2, 32'h2}.
  - done in cycle 8 with out={32'h3, 32'h3}.
